// File: rtl/cpu_pkg.sv
// Shared ID/EXE definitions: default widths, the zero-register index
// and the packed-vector slice helper.
package cpu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int unsigned REG_ZERO = 0;

    // Low bit of element idx in a vector packed as elements of w bits.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/fwd_regfile_if.sv
// Bundle of the register-file read, write-back, forwarding and
// stall-counter signals between the pipeline and fwd_regfile.
interface fwd_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NRD = 2,
    parameter int NFWD = 2,
    parameter int CW = 32,
    localparam int NF = (NFWD > 0) ? NFWD : 1
);

    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              wb_wreg;
    logic [AW-1:0]     wb_wd;
    logic [DW-1:0]     wb_wdata;
    logic [NF-1:0]     fwd_wreg;
    logic [NF*AW-1:0]  fwd_wd;
    logic [NF*DW-1:0]  fwd_wdata;
    logic [NF-1:0]     fwd_pend;
    logic              stall_req;
    logic [CW-1:0]     stall_cnt;
    logic              stall_clr;

    modport master (
        output rd_en, rd_addr,
        output wb_wreg, wb_wd, wb_wdata,
        output fwd_wreg, fwd_wd, fwd_wdata, fwd_pend,
        output stall_clr,
        input  rd_data, stall_req, stall_cnt
    );

    modport slave (
        input  rd_en, rd_addr,
        input  wb_wreg, wb_wd, wb_wdata,
        input  fwd_wreg, fwd_wd, fwd_wdata, fwd_pend,
        input  stall_clr,
        output rd_data, stall_req, stall_cnt
    );

endinterface

// File: rtl/fwd_regfile_sel.sv
// One read port's source select: zero, forwarding stage, same-cycle
// write-back or stored value, plus the load-use hazard for the port.
module fwd_sel
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NFWD = 2,
    localparam int NF = (NFWD > 0) ? NFWD : 1
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    arr_data,
    input  logic             wb_wreg,
    input  logic [AW-1:0]    wb_wd,
    input  logic [DW-1:0]    wb_wdata,
    input  logic [NF-1:0]    fwd_wreg,
    input  logic [NF*AW-1:0] fwd_wd,
    input  logic [NF*DW-1:0] fwd_wdata,
    input  logic [NF-1:0]    fwd_pend,
    output logic [DW-1:0]    data,
    output logic             hazard
);

    logic          hit;
    logic          hit_pend;
    logic [DW-1:0] hit_data;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        hit      = 1'b0;
        hit_pend = 1'b0;
        hit_data = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_wreg[k] &&
                fwd_wd[slice_lo(k, AW) +: AW] == addr) begin
                hit      = 1'b1;
                hit_pend = fwd_pend[k];
                hit_data = fwd_wdata[slice_lo(k, DW) +: DW];
            end
        end
    end

    always_comb begin
        data   = '0;
        hazard = 1'b0;
        if (en && addr != AW'(REG_ZERO)) begin
            if (hit) begin
                hazard = hit_pend;
                data   = hit_pend ? '0 : hit_data;
            end else if (wb_wreg && wb_wd == addr) begin
                data = wb_wdata;
            end else begin
                data = arr_data;
            end
        end
    end

endmodule

// File: rtl/fwd_regfile.sv
// ID-stage register file with write-back bypass, multi-stage
// forwarding, load-use stall request and a saturating stall counter.
module fwd_regfile
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NRD = 2,
    parameter int NFWD = 2,
    parameter int CW = 32,
    localparam int NF = (NFWD > 0) ? NFWD : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              wb_wreg,
    input  logic [AW-1:0]     wb_wd,
    input  logic [DW-1:0]     wb_wdata,
    input  logic [NF-1:0]     fwd_wreg,
    input  logic [NF*AW-1:0]  fwd_wd,
    input  logic [NF*DW-1:0]  fwd_wdata,
    input  logic [NF-1:0]     fwd_pend,
    output logic              stall_req,
    output logic [CW-1:0]     stall_cnt,
    input  logic              stall_clr
);

    localparam int DEPTH = 2 ** AW;

    if (NRD < 1 || NFWD < 0) begin : g_bad_param
        $error("fwd_regfile: NRD must be >= 1 and NFWD >= 0");
    end

    logic [DW-1:0]  mem_q [DEPTH];
    logic [DW-1:0]  mem_d [DEPTH];
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [NRD-1:0] haz;

    always_comb begin
        mem_d = mem_q;
        if (wb_wreg && wb_wd != AW'(REG_ZERO)) begin
            mem_d[wb_wd] = wb_wdata;
        end
        mem_d[0] = '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (stall_req && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        fwd_sel #(
            .DW   (DW),
            .AW   (AW),
            .NFWD (NFWD)
        ) u_sel (
            .en        (rd_en[i]),
            .addr      (rd_addr[slice_lo(i, AW) +: AW]),
            .arr_data  (mem_q[rd_addr[slice_lo(i, AW) +: AW]]),
            .wb_wreg   (wb_wreg),
            .wb_wd     (wb_wd),
            .wb_wdata  (wb_wdata),
            .fwd_wreg  (fwd_wreg),
            .fwd_wd    (fwd_wd),
            .fwd_wdata (fwd_wdata),
            .fwd_pend  (fwd_pend),
            .data      (rd_data[slice_lo(i, DW) +: DW]),
            .hazard    (haz[i])
        );
    end

    assign stall_req = (NFWD == 0) ? 1'b0 : |haz;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_regfile.sv
// Self-checking bench for fwd_regfile: directed scenarios plus random
// traffic against a rule-level reference model.
module tb_fwd_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int NFWD = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fwd_regfile_if #(
        .DW(DW), .AW(AW), .NRD(NRD), .NFWD(NFWD), .CW(32)
    ) bus ();

    logic [NRD*DW-1:0] rd_data_s;
    logic              stall_req_s;
    logic [2:0]        stall_cnt_s;

    fwd_regfile #(
        .DW(DW), .AW(AW), .NRD(NRD), .NFWD(NFWD), .CW(32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_en     (bus.rd_en),
        .rd_addr   (bus.rd_addr),
        .rd_data   (bus.rd_data),
        .wb_wreg   (bus.wb_wreg),
        .wb_wd     (bus.wb_wd),
        .wb_wdata  (bus.wb_wdata),
        .fwd_wreg  (bus.fwd_wreg),
        .fwd_wd    (bus.fwd_wd),
        .fwd_wdata (bus.fwd_wdata),
        .fwd_pend  (bus.fwd_pend),
        .stall_req (bus.stall_req),
        .stall_cnt (bus.stall_cnt),
        .stall_clr (bus.stall_clr)
    );

    fwd_regfile #(
        .DW(DW), .AW(AW), .NRD(NRD), .NFWD(NFWD), .CW(3)
    ) dut_s (
        .clk       (clk),
        .resetn    (resetn),
        .rd_en     (bus.rd_en),
        .rd_addr   (bus.rd_addr),
        .rd_data   (rd_data_s),
        .wb_wreg   (bus.wb_wreg),
        .wb_wd     (bus.wb_wd),
        .wb_wdata  (bus.wb_wdata),
        .fwd_wreg  (bus.fwd_wreg),
        .fwd_wd    (bus.fwd_wd),
        .fwd_wdata (bus.fwd_wdata),
        .fwd_pend  (bus.fwd_pend),
        .stall_req (stall_req_s),
        .stall_cnt (stall_cnt_s),
        .stall_clr (bus.stall_clr)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem_m [32];
    logic [31:0]   cnt_m;
    logic [2:0]    cnt3_m;

    // Reference read: rules applied in order, youngest stage first.
    function automatic logic [DW-1:0] m_rd(input int p, output bit haz);
        logic [AW-1:0] a;
        a = bus.rd_addr[p*AW +: AW];
        haz = 1'b0;
        if (!bus.rd_en[p]) return '0;
        if (a == 0) return '0;
        for (int k = 0; k < NFWD; k++) begin
            if (bus.fwd_wreg[k] && bus.fwd_wd[k*AW +: AW] == a) begin
                if (bus.fwd_pend[k]) begin
                    haz = 1'b1;
                    return '0;
                end
                return bus.fwd_wdata[k*DW +: DW];
            end
        end
        if (bus.wb_wreg && bus.wb_wd == a) return bus.wb_wdata;
        return mem_m[a];
    endfunction

    function automatic bit m_stall();
        bit h;
        bit any;
        logic [DW-1:0] d;
        any = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            d = m_rd(p, h);
            any = any | h;
        end
        return any;
    endfunction

    task automatic tick();
        bit sr;
        sr = m_stall();
        @(posedge clk);
        if (!resetn) begin
            for (int j = 0; j < 32; j++) mem_m[j] = '0;
            cnt_m = '0;
            cnt3_m = '0;
        end else begin
            if (bus.wb_wreg && bus.wb_wd != 0)
                mem_m[bus.wb_wd] = bus.wb_wdata;
            if (bus.stall_clr) begin
                cnt_m = '0;
                cnt3_m = '0;
            end else if (sr) begin
                if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
                if (cnt3_m != 3'd7) cnt3_m = cnt3_m + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.rd_en     = '0;
        bus.rd_addr   = '0;
        bus.wb_wreg   = 1'b0;
        bus.wb_wd     = '0;
        bus.wb_wdata  = '0;
        bus.fwd_wreg  = '0;
        bus.fwd_wd    = '0;
        bus.fwd_wdata = '0;
        bus.fwd_pend  = '0;
        bus.stall_clr = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rd_en[p] = 1'b1;
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_fwd(input int k, input bit w, input int a,
                           input logic [DW-1:0] d, input bit pend);
        bus.fwd_wreg[k] = w;
        bus.fwd_wd[k*AW +: AW] = AW'(a);
        bus.fwd_wdata[k*DW +: DW] = d;
        bus.fwd_pend[k] = pend;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        for (int j = 0; j < 32; j++) mem_m[j] = '0;
        cnt_m = '0;
        cnt3_m = '0;
        #2;
        checks++;
        if (bus.rd_data !== '0 || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rd_data=%h stall_req=%b, want 0/0",
                     bus.rd_data, bus.stall_req);
        end
        bus.wb_wreg = 1'b1;
        bus.wb_wd = 5'd3;
        bus.wb_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tick();
        tick();
        resetn = 1'b1;
        idle();
        set_rd(0, 3);
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_r3: got %h want 0", bus.rd_data[31:0]);
        end
        checks++;
        if (bus.stall_cnt !== 32'd0 || stall_cnt_s !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0",
                     bus.stall_cnt, stall_cnt_s);
        end
    endtask

    task automatic test_write_read();
        idle();
        bus.wb_wreg = 1'b1;
        bus.wb_wd = 5'd5;
        bus.wb_wdata = 32'h1234_5678;
        tick();
        idle();
        set_rd(0, 5);
        set_rd(1, 5);
        #1;
        checks++;
        if (bus.rd_data !== {2{32'h1234_5678}}) begin
            errors++;
            $display("FAIL write_r5: got %h want 1234567812345678",
                     bus.rd_data);
        end
        bus.wb_wreg = 1'b1;
        bus.wb_wd = 5'd0;
        bus.wb_wdata = 32'hFFFF_FFFF;
        set_rd(0, 0);
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_bypass: got %h want 0", bus.rd_data[31:0]);
        end
        tick();
        idle();
        set_rd(0, 0);
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_write: got %h want 0", bus.rd_data[31:0]);
        end
    endtask

    task automatic test_bypass_priority();
        logic [DW-1:0] exp_v [4];
        exp_v[0] = 32'd4;
        exp_v[1] = 32'd3;
        exp_v[2] = 32'd2;
        exp_v[3] = 32'd1;
        idle();
        bus.wb_wreg = 1'b1;
        bus.wb_wd = 5'd7;
        bus.wb_wdata = 32'd1;
        tick();
        bus.wb_wdata = 32'd2;
        set_fwd(1, 1'b1, 7, 32'd3, 1'b0);
        set_fwd(0, 1'b1, 7, 32'd4, 1'b0);
        set_rd(0, 7);
        set_rd(1, 6);
        for (int s = 0; s < 4; s++) begin
            if (s == 1) bus.fwd_wreg[0] = 1'b0;
            if (s == 2) bus.fwd_wreg[1] = 1'b0;
            if (s == 3) bus.wb_wreg = 1'b0;
            #1;
            checks++;
            if (bus.rd_data[31:0] !== exp_v[s]) begin
                errors++;
                $display("FAIL bypass_step%0d: got %h want %h",
                         s, bus.rd_data[31:0], exp_v[s]);
            end
        end
        checks++;
        if (bus.rd_data[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL bypass_r6: got %h want 0", bus.rd_data[63:32]);
        end
    endtask

    task automatic test_load_use();
        idle();
        set_fwd(0, 1'b1, 9, 32'hAAAA_5555, 1'b1);
        set_rd(1, 9);
        #1;
        checks++;
        if (bus.stall_req !== 1'b1 || bus.rd_data[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL load_use: stall=%b data=%h want 1/0",
                     bus.stall_req, bus.rd_data[63:32]);
        end
        bus.rd_en[1] = 1'b0;
        #1;
        checks++;
        if (bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL load_use_noen: stall=%b want 0", bus.stall_req);
        end
        bus.rd_en[1] = 1'b1;
        set_fwd(1, 1'b1, 9, 32'h0BAD_0BAD, 1'b1);
        set_fwd(0, 1'b1, 9, 32'h600D_600D, 1'b0);
        #1;
        checks++;
        if (bus.stall_req !== 1'b0 ||
            bus.rd_data[63:32] !== 32'h600D_600D) begin
            errors++;
            $display("FAIL shadow: stall=%b data=%h want 0/600d600d",
                     bus.stall_req, bus.rd_data[63:32]);
        end
        idle();
        set_fwd(0, 1'b1, 0, 32'h1, 1'b1);
        set_rd(0, 0);
        #1;
        checks++;
        if (bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL pend_r0: stall=%b want 0", bus.stall_req);
        end
    endtask

    task automatic test_counter();
        idle();
        set_fwd(0, 1'b1, 9, 32'h0, 1'b1);
        set_rd(1, 9);
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (bus.stall_cnt !== 32'd5 || stall_cnt_s !== 3'd5) begin
            errors++;
            $display("FAIL cnt5: got %0d/%0d want 5/5",
                     bus.stall_cnt, stall_cnt_s);
        end
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        checks++;
        if (bus.stall_cnt !== 32'd0 || stall_cnt_s !== 3'd0) begin
            errors++;
            $display("FAIL cnt_clr: got %0d/%0d want 0/0",
                     bus.stall_cnt, stall_cnt_s);
        end
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (bus.stall_cnt !== 32'd10 || stall_cnt_s !== 3'd7) begin
            errors++;
            $display("FAIL cnt_sat: got %0d/%0d want 10/7",
                     bus.stall_cnt, stall_cnt_s);
        end
        idle();
        tick();
        checks++;
        if (stall_cnt_s !== 3'd7) begin
            errors++;
            $display("FAIL cnt_hold: got %0d want 7", stall_cnt_s);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        bit h;
        for (int n = 0; n < 300; n++) begin
            bus.rd_en = NRD'($urandom);
            for (int p = 0; p < NRD; p++)
                bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            bus.wb_wreg = 1'($urandom);
            bus.wb_wd = AW'($urandom_range(0, 7));
            bus.wb_wdata = $urandom;
            for (int k = 0; k < NFWD; k++)
                set_fwd(k, 1'($urandom), $urandom_range(0, 7), $urandom,
                        $urandom_range(0, 3) == 0);
            bus.stall_clr = ($urandom_range(0, 15) == 0);
            #1;
            for (int p = 0; p < NRD; p++) begin
                exp_d = m_rd(p, h);
                checks++;
                if (bus.rd_data[p*DW +: DW] !== exp_d ||
                    rd_data_s[p*DW +: DW] !== exp_d) begin
                    errors++;
                    $display("FAIL rand_rd%0d n=%0d: got %h/%h want %h",
                             p, n, bus.rd_data[p*DW +: DW],
                             rd_data_s[p*DW +: DW], exp_d);
                end
            end
            checks++;
            if (bus.stall_req !== m_stall() || stall_req_s !== m_stall()) begin
                errors++;
                $display("FAIL rand_stall n=%0d: got %b/%b want %b",
                         n, bus.stall_req, stall_req_s, m_stall());
            end
            checks++;
            if (bus.stall_cnt !== cnt_m || stall_cnt_s !== cnt3_m) begin
                errors++;
                $display("FAIL rand_cnt n=%0d: got %0d/%0d want %0d/%0d",
                         n, bus.stall_cnt, stall_cnt_s, cnt_m, cnt3_m);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        idle();
        for (int r = 1; r < 8; r++) begin
            bus.wb_wreg = 1'b1;
            bus.wb_wd = AW'(r);
            bus.wb_wdata = 32'h100 + r;
            tick();
        end
        idle();
        set_fwd(0, 1'b1, 4, 32'h0, 1'b1);
        set_rd(0, 4);
        tick();
        tick();
        idle();
        set_rd(0, 1);
        set_rd(1, 2);
        #1;
        checks++;
        if (bus.rd_data !== {32'h102, 32'h101} || bus.stall_cnt === 0) begin
            errors++;
            $display("FAIL pre_reset: data=%h cnt=%0d want 102/101,cnt>0",
                     bus.rd_data, bus.stall_cnt);
        end
        #1;
        resetn = 1'b0;
        for (int j = 0; j < 32; j++) mem_m[j] = '0;
        cnt_m = '0;
        cnt3_m = '0;
        #1;
        checks++;
        if (bus.rd_data !== '0 || bus.stall_cnt !== 0 ||
            stall_cnt_s !== 0) begin
            errors++;
            $display("FAIL async_reset: data=%h cnt=%0d/%0d want 0",
                     bus.rd_data, bus.stall_cnt, stall_cnt_s);
        end
        for (int r = 1; r < 32; r++) begin
            set_rd(0, r);
            #1;
            checks++;
            if (bus.rd_data[31:0] !== 32'h0) begin
                errors++;
                $display("FAIL reset_scan r%0d: got %h want 0",
                         r, bus.rd_data[31:0]);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass_priority();
        test_load_use();
        test_counter();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_regfile.md
Name: fwd_regfile

Overview:
- Parametrised successor to the current fixed 2-read/32x32 register file plus the ID-stage forwarding muxes.
- Merges register storage, write-back bypass and an N-stage forwarding network into one block.
- Adds load-use hazard detection (stall request) and a saturating stall-cycle performance counter.
- Sits in ID: read addresses come from the decoder, forwarding sources from EX/MEM, writes from MEM_WB.

Parameters:
- DW, 32, data width in bits.
- AW, 5, register address width; depth = 2**AW entries.
- NRD, 2, number of read ports.
- NFWD, 2, number of forwarding sources; index 0 = youngest stage (EX), NFWD-1 = oldest (MEM).
- CW, 32, stall counter width.

Ports:
- clk, input, 1, rising-edge clock.
- resetn, input, 1, asynchronous active-low reset.
- rd_en, input, NRD, per-port read enable.
- rd_addr, input, NRD*AW, packed read addresses; port i uses bits [i*AW +: AW].
- rd_data, output, NRD*DW, packed read data.
- wb_wreg, input, 1, write-back write enable.
- wb_wd, input, AW, write-back destination.
- wb_wdata, input, DW, write-back data.
- fwd_wreg, input, NFWD, per-stage "will write a register" flag.
- fwd_wd, input, NFWD*AW, per-stage destination.
- fwd_wdata, input, NFWD*DW, per-stage result.
- fwd_pend, input, NFWD, per-stage "result not yet valid" flag (load in flight).
- stall_req, output, 1, load-use hazard; the pipeline must hold PC/IF_ID and bubble ID_EX.
- stall_cnt, output, CW, saturating count of cycles with stall_req=1.
- stall_clr, input, 1, synchronous clear of stall_cnt.

Behaviour:
- Storage: 2**AW x DW register array. Entry 0 is hardwired to zero and never written.
- Reset: resetn=0 asynchronously clears every array entry and stall_cnt to 0. With all inputs idle, rd_data=0 and stall_req=0 while reset is held.
- Write: on posedge clk, if wb_wreg=1 and wb_wd!=0, array[wb_wd] <= wb_wdata.
- Read path is combinational, zero latency. For each port i, the first matching rule applies:
  1. rd_en[i]=0 -> rd_data_i = 0, no hazard.
  2. rd_addr_i = 0 -> 0.
  3. Lowest k with fwd_wreg[k]=1 and fwd_wd_k = rd_addr_i -> fwd_wdata_k. If fwd_pend[k]=1, port i is hazardous and rd_data_i = 0.
  4. wb_wreg=1 and wb_wd = rd_addr_i -> wb_wdata (same-cycle write-through).
  5. Otherwise -> array[rd_addr_i].
- Priority: only the youngest matching stage counts. An older pending stage shadowed by a younger non-pending match to the same register does not stall.
- A pending stage with fwd_wd=0 never causes a hazard.
- stall_req = OR of all port hazards.
- stall_cnt update on posedge clk:
  - stall_clr=1 -> 0 (clear wins over increment).
  - else if stall_req=1 and stall_cnt != all-ones -> increment.
  - Saturates at 2**CW-1; never wraps.
- Reset mid-operation: asynchronous reset overrides any write or counter update in the same cycle.
- Bounds: NRD >= 1, NFWD >= 0. With NFWD=0, rule 3 is removed and stall_req is tied to 0. Illegal parameter values are checked at elaboration.

Decomposition:
- Shared package cpu_pkg: DW/AW defaults, the REG_ZERO constant, and the packed-slice helper function used by ID/EXE.
- One sub-module, fwd_sel: a per-port priority mux (rules 1-5) producing data plus a hazard bit, instantiated NRD times by generate.
- The array, write logic and stall counter stay in fwd_regfile.

Test Plan:
1. Reset: hold resetn=0 with wb_wreg=1 writing 0xDEADBEEF to r3 -> r3 still reads 0 after release; stall_cnt=0.
2. Write/read: write r5=0x12345678, next cycle read r5 -> 0x12345678. Write r0=0xFFFFFFFF -> r0 reads 0.
3. Bypass priority: array r7=1, wb r7=2, fwd[1] r7=3, fwd[0] r7=4 -> rd_data=4. Drop fwd[0] -> 3. Drop fwd[1] -> 2. Drop wb -> 1.
4. Load-use: fwd[0] r9 with pend=1, port 1 reads r9 -> stall_req=1 and rd_data_1=0. Set rd_en[1]=0 -> stall_req=0. Add a younger non-pending match shadowing a pending fwd[1] -> stall_req=0.
5. Counter: stall_req high for 5 cycles -> stall_cnt=5. Pulse stall_clr together with stall_req -> 0. With CW=3, 10 stall cycles -> stall_cnt saturates at 7.
6. Async reset mid-run: assert resetn low between clock edges -> array and stall_cnt zero immediately, without waiting for a clock edge.
